// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: fetches 4-bit commands from a script ROM and issues them
// to the LCD engine over cmd/cmd_valid/busy until the WRITE command completes.
module lcd_cmd_sequencer #(
  parameter int unsigned AW      = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          scr_rd,
  output logic [AW-1:0] scr_a,
  input  logic [3:0]    scr_q,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic          seq_busy,
  output logic          seq_done,
  output logic          seq_err,
  output logic [1:0]    err_code,
  output logic [AW:0]   issued_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [AW-1:0] LAST_A  = '1;
  localparam logic [AW-1:0] A_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_MAX = '1;
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [TW-1:0] T_LIM   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [3:0]    MAX_CMD = 4'd11;
  localparam logic [3:0]    CMD_WR  = 4'd0;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ILL  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_END  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_Q, ISSUE, GUARD, WAIT_DONE, FINISH, ERROR
  } state_t;

  state_t          state, state_d;
  logic [AW-1:0]   scr_a_d;
  logic [3:0]      cmd_d;
  logic [1:0]      err_d;
  logic [AW:0]     issued_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic            tmo;

  // Next-state, datapath updates and the busy-qualified command strobe.
  // cmd_valid is a live decode of ISSUE and busy so it can never coincide
  // with busy=1, and it vanishes with the state on an asynchronous reset.
  always_comb begin
    state_d   = state;
    scr_a_d   = scr_a;
    cmd_d     = cmd;
    err_d     = err_code;
    issued_d  = issued_cnt;
    cmd_valid = 1'b0;
    tmo       = (tcnt == T_LIM);

    case (state)
      IDLE, FINISH, ERROR: begin
        if (start) begin
          state_d  = FETCH;
          scr_a_d  = '0;
          issued_d = '0;
          err_d    = ERR_NONE;
        end
      end
      FETCH: state_d = WAIT_Q;
      WAIT_Q: begin
        cmd_d = scr_q;
        if (scr_q > MAX_CMD) begin
          state_d = ERROR;
          err_d   = ERR_ILL;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!busy) begin
          cmd_valid = 1'b1;
          if (issued_cnt != CNT_MAX) issued_d = issued_cnt + CNT_ONE;
          state_d = (cmd == CMD_WR) ? WAIT_DONE : GUARD;
        end else if (tmo) begin
          state_d = ERROR;
          err_d   = ERR_TMO;
        end
      end
      GUARD: begin
        if (scr_a == LAST_A) begin
          state_d = ERROR;
          err_d   = ERR_END;
        end else begin
          scr_a_d = scr_a + A_ONE;
          state_d = FETCH;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          state_d = FINISH;
        end else if (tmo) begin
          state_d = ERROR;
          err_d   = ERR_TMO;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state)
      tcnt_d = '0;
    else if (state == ISSUE || state == WAIT_DONE)
      tcnt_d = tcnt + T_ONE;
    else
      tcnt_d = '0;
  end

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      scr_a      <= '0;
      cmd        <= '0;
      err_code   <= ERR_NONE;
      issued_cnt <= '0;
      tcnt       <= '0;
      scr_rd     <= 1'b0;
      seq_busy   <= 1'b0;
      seq_done   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_d;
      scr_a      <= scr_a_d;
      cmd        <= cmd_d;
      err_code   <= err_d;
      issued_cnt <= issued_d;
      tcnt       <= tcnt_d;
      scr_rd     <= (state_d == FETCH);
      seq_busy   <= !(state_d == IDLE || state_d == FINISH || state_d == ERROR);
      seq_done   <= (state_d == FINISH);
      seq_err    <= (state_d == ERROR);
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: script ROM and LCD engine models, script-level
// reference of the expected command trace and termination status.
module tb_lcd_cmd_sequencer;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned TO_A  = 1024;
  localparam int unsigned TO_B  = 16;
  localparam int unsigned CMAX  = (1 << (AW + 1)) - 1;

  logic          clk = 1'b0;
  logic          reset, start, scr_rd, cmd_valid, busy, done;
  logic          seq_busy, seq_done, seq_err;
  logic [AW-1:0] scr_a;
  logic [3:0]    scr_q, cmd;
  logic [1:0]    err_code;
  logic [AW:0]   issued_cnt;

  logic          b_start, b_scr_rd, b_cmd_valid, b_busy, b_done;
  logic          b_seq_busy, b_seq_done, b_seq_err;
  logic [AW-1:0] b_scr_a;
  logic [3:0]    b_scr_q, b_cmd;
  logic [1:0]    b_err_code;
  logic [AW:0]   b_issued_cnt;

  lcd_cmd_sequencer #(.AW(AW), .TIMEOUT(TO_A)) u_dut (
    .clk(clk), .reset(reset), .start(start), .scr_rd(scr_rd), .scr_a(scr_a),
    .scr_q(scr_q), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err),
    .err_code(err_code), .issued_cnt(issued_cnt)
  );

  lcd_cmd_sequencer #(.AW(AW), .TIMEOUT(TO_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .scr_rd(b_scr_rd), .scr_a(b_scr_a),
    .scr_q(b_scr_q), .cmd(b_cmd), .cmd_valid(b_cmd_valid), .busy(b_busy), .done(b_done),
    .seq_busy(b_seq_busy), .seq_done(b_seq_done), .seq_err(b_seq_err),
    .err_code(b_err_code), .issued_cnt(b_issued_cnt)
  );

  always #5 clk = ~clk;

  // Environment model state
  logic [3:0]    rom   [DEPTH];
  logic [3:0]    b_rom [DEPTH];
  bit            rd_pend, b_rd_pend, prev_valid, rnd_busy, b_stuck;
  logic [AW-1:0] a_pend, b_a_pend;
  logic [3:0]    prev_cmd;
  int            busy_cnt, done_cnt, busy_len, done_dly;
  int            b_pulses, b_t_rd, cyc, t_end, n;
  int unsigned   obs[$], t_pulse[$], exp_q[$], first_q[$];
  int unsigned   exp_err, exp_a, exp_cnt;
  int            n_cmp, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_models();
    rd_pend = 1'b0; b_rd_pend = 1'b0; prev_valid = 1'b0; prev_cmd = 4'd0;
    busy_cnt = 0; done_cnt = 0; busy = 1'b0; done = 1'b0;
    b_stuck = 1'b0; b_busy = 1'b0; b_pulses = 0;
  endtask

  task automatic fill_rom(input logic [3:0] v);
    for (int i = 0; i < DEPTH; i++) rom[i] = v;
  endtask

  // Script-level reference: walk the ROM until WRITE, an illegal code or the end.
  function automatic void build_expect();
    exp_q.delete();
    exp_err = 3;
    exp_a   = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] > 4'd11) begin
        exp_err = 1; exp_a = i; break;
      end
      exp_q.push_back(32'(rom[i]));
      if (rom[i] == 4'd0) begin
        exp_err = 0; exp_a = i; break;
      end
    end
    exp_cnt = (exp_q.size() > CMAX) ? CMAX : exp_q.size();
  endfunction

  // One clock: update ROM/engine responses after the edge, then sample outputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_pend) scr_q = rom[a_pend];
    if (prev_valid) begin
      busy_cnt = busy_len;
      if (prev_cmd == 4'd0) done_cnt = done_dly;
    end
    done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) done = 1'b1;
    end
    busy = (busy_cnt > 0) || (rnd_busy && ($urandom_range(0, 3) == 0));
    if (busy_cnt > 0) busy_cnt--;
    if (b_rd_pend) b_scr_q = b_rom[b_a_pend];
    b_busy = b_stuck;
    #1;
    rd_pend = scr_rd; a_pend = scr_a; prev_valid = cmd_valid; prev_cmd = cmd;
    if (cmd_valid) begin
      check("valid_busy", 32'(busy), 0);
      obs.push_back(32'(cmd));
      t_pulse.push_back(cyc);
    end
    b_rd_pend = b_scr_rd; b_a_pend = b_scr_a;
    if (b_scr_rd) b_t_rd = cyc;
    if (b_cmd_valid) begin
      check("b_valid_busy", 32'(b_busy), 0);
      b_pulses++;
      b_stuck = 1'b1;
    end
  endtask

  task automatic run_a(input bit mid_start);
    int k = 0;
    obs.delete(); t_pulse.delete();
    start = 1'b1; step(); start = 1'b0;
    while (seq_busy && k < 6000) begin
      if (mid_start && ($urandom_range(0, 15) == 0)) start = 1'b1;
      step();
      start = 1'b0;
      k++;
    end
    t_end = cyc;
    check("run_end", 32'(seq_busy), 0);
  endtask

  task automatic check_run();
    check("trace_len", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      check("trace_cmd", obs[i], exp_q[i]);
    check("err_code", 32'(err_code), exp_err);
    check("seq_done", 32'(seq_done), 32'(exp_err == 0));
    check("seq_err", 32'(seq_err), 32'(exp_err != 0));
    check("scr_a", 32'(scr_a), exp_a);
    check("issued_cnt", 32'(issued_cnt), exp_cnt);
  endtask

  task automatic check_zero();
    check("rst_scr_rd", 32'(scr_rd), 0);
    check("rst_scr_a", 32'(scr_a), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_seq_busy", 32'(seq_busy), 0);
    check("rst_seq_done", 32'(seq_done), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_issued", 32'(issued_cnt), 0);
  endtask

  task automatic load_basic();
    fill_rom(4'd1);
    rom[0] = 4'd1; rom[1] = 4'd3; rom[2] = 4'd5; rom[3] = 4'd9; rom[4] = 4'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; b_t_rd = 0;
    reset = 1'b1; start = 1'b0; scr_q = 4'd0;
    b_start = 1'b0; b_done = 1'b0; b_scr_q = 4'd0;
    busy_len = 0; done_dly = 1; rnd_busy = 1'b0;
    reset_models();
    for (int i = 0; i < DEPTH; i++) b_rom[i] = 4'd7;
    b_rom[0] = 4'd2;
    repeat (3) @(posedge clk);
    #2;
    check_zero();
    check("rst_b_busy", 32'(b_seq_busy), 0);
    reset = 1'b0;

    // Basic script with a 3-cycle busy engine and done 70 cycles after WRITE
    load_basic(); busy_len = 3; done_dly = 70; rnd_busy = 1'b0;
    build_expect(); run_a(1'b0); check_run();
    for (int i = 1; i < t_pulse.size(); i++)
      check("cmd_gap", t_pulse[i] - t_pulse[i-1], 4);
    if (t_pulse.size() > 0)
      check("done_lat", 32'(t_end) - t_pulse[t_pulse.size()-1], 32'(done_dly + 1));
    first_q = obs;

    // Restart from FINISH gives an identical trace
    run_a(1'b0); check_run();
    check("rerun_len", 32'(obs.size()), 32'(first_q.size()));
    for (int i = 0; i < obs.size() && i < first_q.size(); i++)
      check("rerun_cmd", obs[i], first_q[i]);

    // Illegal command after one legal one
    fill_rom(4'd1); rom[0] = 4'd4; rom[1] = 4'd12;
    build_expect(); run_a(1'b0); check_run();

    // Script of all 1s runs off the end
    fill_rom(4'd1);
    build_expect(); run_a(1'b0); check_run();

    // Reset during a strobe, then a clean rerun
    load_basic(); busy_len = 2; done_dly = 10;
    obs.delete(); t_pulse.delete();
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (obs.size() < 3 && n < 200) begin step(); n++; end
    check("pre_rst_pulses", 32'(obs.size()), 3);
    reset = 1'b1;
    #1;
    check_zero();
    repeat (3) begin
      step();
      check("rst_hold_rd", 32'(scr_rd), 0);
      check("rst_hold_valid", 32'(cmd_valid), 0);
    end
    reset = 1'b0;
    reset_models();
    build_expect(); run_a(1'b0); check_run();

    // Timeout instance: busy stuck high after its first command
    b_start = 1'b1; step(); b_start = 1'b0;
    n = 0;
    while (b_seq_busy && n < 300) begin step(); n++; end
    check("b_end", 32'(b_seq_busy), 0);
    check("b_seq_err", 32'(b_seq_err), 1);
    check("b_err_code", 32'(b_err_code), 2);
    check("b_pulses", 32'(b_pulses), 1);
    check("b_issued", 32'(b_issued_cnt), 1);
    check("b_scr_a", 32'(b_scr_a), 1);
    check("b_tmo_lat", 32'(cyc - b_t_rd), 32'(2 + TO_B));

    // Randomized scripts, engine latencies and stray start pulses
    rnd_busy = 1'b1;
    for (int r = 0; r < 20; r++) begin
      int unsigned kind, p;
      kind = $urandom_range(0, 2);
      p    = $urandom_range(0, DEPTH - 1);
      for (int i = 0; i < DEPTH; i++) rom[i] = 4'($urandom_range(1, 11));
      if (kind == 0) rom[p] = 4'd0;
      else if (kind == 1) rom[p] = 4'($urandom_range(12, 15));
      busy_len = $urandom_range(0, 6);
      done_dly = $urandom_range(1, 300);
      build_expect(); run_a(1'b1); check_run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
